// File: rtl/bytebeat_pwm_sink.sv
// Bytebeat sample sink: a 2-entry FIFO feeding a free-running PWM renderer.
// One sample is consumed per 2^WIDTH enabled cycles, and a sticky flag reports underrun.
module bytebeat_pwm_sink #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] sample_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             clear_i,
  output logic             pwm_o,
  output logic             period_start_o,
  output logic             underrun_o
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] duty;
  logic [WIDTH-1:0] fifo_mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;

  logic push;
  logic pop;
  logic wrap;
  logic starve;

  assign ready_o = (count < 2'd2);
  assign push    = valid_i && ready_o;
  assign wrap    = enable_i && (cnt == CNT_MAX);
  // Pop decision uses the pre-push count, so a same-cycle push never bypasses.
  assign pop     = wrap && (count != 2'd0);
  assign starve  = wrap && (count == 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= sample_i;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      duty <= '0;
    end else begin
      if (enable_i) begin
        cnt <= cnt + CNT_ONE;
      end
      if (pop) begin
        duty <= fifo_mem[rd_ptr];
      end
    end
  end

  // Outputs lag the cnt/duty comparison by one cycle; disabling forces silence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_o          <= 1'b0;
      period_start_o <= 1'b0;
      underrun_o     <= 1'b0;
    end else begin
      pwm_o          <= enable_i && (cnt < duty);
      period_start_o <= wrap;
      if (starve) begin
        underrun_o <= 1'b1;
      end else if (clear_i) begin
        underrun_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bytebeat_pwm_sink.sv
// Scenario bench for bytebeat_pwm_sink, checked each cycle against a queue-based
// behavioural model plus period-level expectations (high counts, acceptance edges).
module tb_bytebeat_pwm_sink;

  localparam int WIDTH  = 8;
  localparam int PERIOD = 256;

  logic             clk      = 1'b0;
  logic             rst      = 1'b0;
  logic             enable_i = 1'b0;
  logic             valid_i  = 1'b0;
  logic             clear_i  = 1'b0;
  logic [WIDTH-1:0] sample_i = '0;
  logic             ready_o;
  logic             pwm_o;
  logic             period_start_o;
  logic             underrun_o;

  int n_checks = 0;
  int n_fail   = 0;

  int m_cnt  = 0;
  int m_duty = 0;
  int m_q[$];
  bit m_pwm   = 1'b0;
  bit m_ps    = 1'b0;
  bit m_under = 1'b0;

  bytebeat_pwm_sink #(.WIDTH(WIDTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable_i       (enable_i),
    .sample_i       (sample_i),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .clear_i        (clear_i),
    .pwm_o          (pwm_o),
    .period_start_o (period_start_o),
    .underrun_o     (underrun_o)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_vec();
    return {logic'(m_q.size() < 2), logic'(m_pwm), logic'(m_ps), logic'(m_under)};
  endfunction

  function automatic logic [3:0] obs_vec();
    return {ready_o, pwm_o, period_start_o, underrun_o};
  endfunction

  task automatic model_reset();
    m_cnt   = 0;
    m_duty  = 0;
    m_q.delete();
    m_pwm   = 1'b0;
    m_ps    = 1'b0;
    m_under = 1'b0;
  endtask

  // Predicts the state after the coming rising edge from the inputs now applied.
  task automatic model_step();
    bit wrap;
    bit push;
    wrap    = enable_i && (m_cnt == PERIOD - 1);
    push    = valid_i && (m_q.size() < 2);
    m_pwm   = enable_i && (m_cnt < m_duty);
    m_ps    = wrap;
    if (wrap && m_q.size() == 0) m_under = 1'b1;
    else if (clear_i)            m_under = 1'b0;
    if (wrap && m_q.size() > 0)  m_duty = m_q.pop_front();
    if (push)                    m_q.push_back(int'(sample_i));
    if (enable_i)                m_cnt = (m_cnt + 1) % PERIOD;
  endtask

  task automatic tick();
    if (rst) model_reset();
    else     model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    model_reset();
    enable_i = 1'b0;
    valid_i  = 1'b0;
    clear_i  = 1'b0;
    sample_i = '0;
    repeat (2) tick();
    rst      = 1'b0;
    enable_i = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    sample_i = 8'hF0;
    for (int e = 1; e <= 514; e++) begin
      valid_i = (e == 1);
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL reset_prerun e=%0d: got %b expected %b (ready,pwm,start,underrun)", e, obs_vec(), exp_vec());
      end
    end
    valid_i = 1'b1;
    for (int k = 0; k < 32; k++) begin
      if (k < 2) sample_i = WIDTH'($urandom);
      else       valid_i  = 1'b0;
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL reset_fill k=%0d: got %b expected %b", k, obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if ({ready_o, pwm_o, underrun_o} !== 3'b011) begin
      n_fail++;
      $display("[TB] FAIL reset_pre_state: got ready,pwm,underrun=%b expected 011", {ready_o, pwm_o, underrun_o});
    end
    #2 rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (pwm_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pwm: got %b expected 0", pwm_o); end
    n_checks++;
    if (underrun_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_underrun: got %b expected 0", underrun_o); end
    n_checks++;
    if (ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b expected 1", ready_o); end
    @(negedge clk);
    tick();
    rst = 1'b0;
    for (int e = 1; e <= 256; e++) begin
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL reset_post e=%0d: got %b expected %b", e, obs_vec(), exp_vec());
      end
      if (e == 255) begin
        n_checks++;
        if (underrun_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_no_early_underrun: got %b expected 0", underrun_o); end
      end
      if (e == 256) begin
        n_checks++;
        if ({period_start_o, underrun_o} !== 2'b11) begin
          n_fail++;
          $display("[TB] FAIL reset_first_wrap: got start,underrun=%b expected 11", {period_start_o, underrun_o});
        end
      end
    end
  endtask

  task automatic test_single_sample();
    int ones;
    int pat_err;
    int ps_cnt;
    do_reset();
    sample_i = 8'h40;
    for (int e = 1; e <= 256; e++) begin
      valid_i = (e == 10);
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL single_fill e=%0d: got %b expected %b", e, obs_vec(), exp_vec());
      end
    end
    valid_i = 1'b0;
    n_checks++;
    if (period_start_o !== 1'b1) begin n_fail++; $display("[TB] FAIL single_first_start: got %b expected 1", period_start_o); end
    ones = 0; pat_err = 0; ps_cnt = 0;
    for (int i = 1; i <= 512; i++) begin
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL single_cycle i=%0d: got %b expected %b", i, obs_vec(), exp_vec());
      end
      if (i <= 256) begin
        ones += int'(pwm_o);
        if (pwm_o !== logic'(i <= 64)) pat_err++;
      end
      if (period_start_o === 1'b1) ps_cnt++;
    end
    n_checks++;
    if (ones !== 64) begin n_fail++; $display("[TB] FAIL single_high_count: got %0d expected 64", ones); end
    n_checks++;
    if (pat_err !== 0) begin n_fail++; $display("[TB] FAIL single_pattern: got %0d misplaced cycles expected 0", pat_err); end
    n_checks++;
    if (ps_cnt !== 2) begin n_fail++; $display("[TB] FAIL single_start_pulses: got %0d expected 2", ps_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [3];
    int acc_edge [3];
    int exp_edge [3];
    int exp_per  [4];
    int periods[$];
    int idx;
    int ones;
    bit acc;
    vals     = '{8'h10, 8'h20, 8'h30};
    exp_edge = '{1, 2, 257};
    exp_per  = '{0, 16, 32, 48};
    acc_edge = '{-1, -1, -1};
    do_reset();
    idx = 0; ones = 0;
    valid_i  = 1'b1;
    sample_i = vals[0];
    for (int e = 1; e <= 1030; e++) begin
      acc = valid_i && ready_o;
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL b2b_cycle e=%0d: got %b expected %b", e, obs_vec(), exp_vec());
      end
      if (acc && idx < 3) begin acc_edge[idx] = e; idx++; end
      if (e == 2) begin
        n_checks++;
        if (ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_ready_low: got %b expected 0", ready_o); end
      end
      ones += int'(pwm_o);
      if (period_start_o === 1'b1) begin periods.push_back(ones); ones = 0; end
      if (idx < 3) sample_i = vals[idx];
      else         valid_i  = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (acc_edge[i] !== exp_edge[i]) begin
        n_fail++;
        $display("[TB] FAIL b2b_accept[%0d]: got edge %0d expected edge %0d", i, acc_edge[i], exp_edge[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (periods.size() <= i || periods[i] !== exp_per[i]) begin
        n_fail++;
        $display("[TB] FAIL b2b_period[%0d]: got %0d high cycles (periods seen %0d) expected %0d",
                 i, (periods.size() > i) ? periods[i] : -1, periods.size(), exp_per[i]);
      end
    end
  endtask

  task automatic test_extremes();
    int periods[$];
    int ones;
    do_reset();
    ones = 0;
    for (int e = 1; e <= 1030; e++) begin
      valid_i  = (e <= 2);
      sample_i = (e == 1) ? 8'h00 : 8'hFF;
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL extreme_cycle e=%0d: got %b expected %b", e, obs_vec(), exp_vec());
      end
      if (e == 768) begin
        n_checks++;
        if (pwm_o !== 1'b0) begin n_fail++; $display("[TB] FAIL extreme_ff_low_slot: got %b expected 0", pwm_o); end
      end
      ones += int'(pwm_o);
      if (period_start_o === 1'b1) begin periods.push_back(ones); ones = 0; end
    end
    n_checks++;
    if (periods.size() < 3 || periods[1] !== 0) begin
      n_fail++;
      $display("[TB] FAIL extreme_zero: got %0d high cycles expected 0", (periods.size() > 1) ? periods[1] : -1);
    end
    n_checks++;
    if (periods.size() < 3 || periods[2] !== 255) begin
      n_fail++;
      $display("[TB] FAIL extreme_full: got %0d high cycles expected 255", (periods.size() > 2) ? periods[2] : -1);
    end
  endtask

  task automatic test_underrun_clear();
    int periods[$];
    int ones;
    do_reset();
    ones = 0;
    sample_i = 8'h80;
    for (int e = 1; e <= 820; e++) begin
      valid_i = (e == 1);
      clear_i = (e == 600 || e == 768 || e == 800);
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL underrun_cycle e=%0d: got %b expected %b", e, obs_vec(), exp_vec());
      end
      ones += int'(pwm_o);
      if (period_start_o === 1'b1) begin periods.push_back(ones); ones = 0; end
      if (e == 512 || e == 600 || e == 768 || e == 800) begin
        n_checks++;
        if (underrun_o !== logic'(e == 512 || e == 768)) begin
          n_fail++;
          $display("[TB] FAIL underrun_flag e=%0d: got %b expected %b", e, underrun_o, logic'(e == 512 || e == 768));
        end
      end
    end
    clear_i = 1'b0;
    n_checks++;
    if (periods.size() < 3 || periods[2] !== 128) begin
      n_fail++;
      $display("[TB] FAIL underrun_repeat: got %0d high cycles expected 128", (periods.size() > 2) ? periods[2] : -1);
    end
  endtask

  task automatic test_enable_gating();
    int x;
    int ones;
    int gated_err;
    int first_ps;
    x = $urandom_range(1, 254);
    do_reset();
    ones = 0; gated_err = 0; first_ps = -1;
    sample_i = WIDTH'(x);
    for (int e = 1; e <= 600; e++) begin
      valid_i  = (e == 1);
      enable_i = !(e >= 357 && e <= 406);
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL gate_cycle e=%0d: got %b expected %b", e, obs_vec(), exp_vec());
      end
      if (e > 256 && e <= 562) ones += int'(pwm_o);
      if (e >= 357 && e <= 406 && (pwm_o !== 1'b0 || period_start_o !== 1'b0)) gated_err++;
      if (e > 256 && first_ps < 0 && period_start_o === 1'b1) first_ps = e;
    end
    enable_i = 1'b1;
    n_checks++;
    if (gated_err !== 0) begin n_fail++; $display("[TB] FAIL gate_silent: got %0d active cycles expected 0", gated_err); end
    n_checks++;
    if (first_ps !== 562) begin n_fail++; $display("[TB] FAIL gate_wrap_edge: got %0d expected 562", first_ps); end
    n_checks++;
    if (ones !== x) begin n_fail++; $display("[TB] FAIL gate_high_count: got %0d expected %0d", ones, x); end
  endtask

  task automatic test_random();
    do_reset();
    for (int e = 1; e <= 3000; e++) begin
      valid_i  = (e <= 1500) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 399) == 0);
      sample_i = WIDTH'($urandom);
      enable_i = ($urandom_range(0, 9) != 0);
      clear_i  = ($urandom_range(0, 31) == 0);
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL random_cycle e=%0d: got %b expected %b", e, obs_vec(), exp_vec());
      end
    end
    valid_i  = 1'b0;
    clear_i  = 1'b0;
    enable_i = 1'b1;
  endtask

  initial begin
    #1;
    test_reset();
    test_single_sample();
    test_back_to_back();
    test_extremes();
    test_underrun_clear();
    test_enable_gating();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bytebeat_pwm_sink.md
# bytebeat_pwm_sink

Consumer end of the bytebeat sample stream: accepts 8-bit unsigned samples from the generator over a valid/ready handshake and renders them as a single-bit PWM audio output, one sample per PWM period. A 2-entry FIFO decouples generator timing from the PWM period. Underrun is reported through a sticky flag. The block sits between the bytebeat core and an output pin of the top-level tile.

## Interface
- WIDTH, default 8: sample width and PWM counter width; PWM period is 2^WIDTH cycles.
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- enable_i  input  1  PWM run enable.
- sample_i  input  WIDTH  unsigned sample from the generator.
- valid_i  input  1  sample_i is valid this cycle.
- ready_o  output  1  FIFO can accept a sample; combinational from FIFO count.
- clear_i  input  1  clears underrun_o.
- pwm_o  output  1  registered PWM audio bit.
- period_start_o  output  1  one-cycle pulse at the start of each PWM period.
- underrun_o  output  1  sticky underrun flag.

## Operation
- FIFO: 2 entries, in-order. ready_o = (count < 2). A push occurs when valid_i && ready_o. There is no bypass: a sample pushed in cycle T cannot be popped before cycle T+1.
- The FIFO accepts pushes regardless of enable_i.
- Counter cnt (WIDTH bits):
  - Increments each cycle enable_i is high.
  - Wraps from 2^WIDTH-1 to 0.
  - Holds its value when enable_i is low.
- Wrap event: cnt == 2^WIDTH-1 && enable_i.
  - FIFO non-empty: pop head into duty.
  - FIFO empty: duty keeps its previous value and underrun_o is set.
- Push and pop in the same cycle with count == 1: count stays 1, and ordering is preserved.
- Pop attempt on an empty FIFO while a push occurs in the same cycle: the pop counts as an underrun; the pushed sample is stored for the next period.
- pwm_o:
  - enable_i high: pwm_o <= (cnt < duty), compared as unsigned.
  - enable_i low: pwm_o <= 0.
  - duty = 0 gives pwm_o constantly 0. duty = 2^WIDTH-1 gives 255 of 256 cycles high.
- period_start_o <= (cnt == 2^WIDTH-1 && enable_i). It is therefore high in the cycle cnt == 0.
- underrun_o:
  - Set on a wrap event with an empty FIFO.
  - Cleared by clear_i.
  - Set wins if both occur in the same cycle.
- Reset (asynchronous, any time including mid-period):
  - cnt = 0, duty = 0, FIFO empty, pwm_o = 0, period_start_o = 0, underrun_o = 0.
  - ready_o = 1 while rst is high and after release.
  - Any partially played period and any buffered samples are discarded.

## Timing
- ready_o has zero latency from FIFO state. A sample is accepted on the edge where valid_i && ready_o.
- Duty load occurs on the wrap edge. In the next cycle, cnt = 0 with the new duty, and period_start_o = 1.
- pwm_o lags the cnt/duty comparison by one cycle. For duty D loaded at wrap edge W, pwm_o is high for exactly D consecutive cycles starting at edge W+1, then low for 2^WIDTH-D cycles.
- Sample-to-audio latency: a sample pushed into an empty FIFO at least one cycle before a wrap edge plays in the period that edge starts. Otherwise it waits for the following wrap edge.
- Steady state: one pop per 2^WIDTH enabled cycles. With the FIFO full, ready_o deasserts until the next wrap edge and reasserts in the cycle after the pop.
- Deasserting enable_i freezes cnt and duty and drives pwm_o to 0 from the next edge. Reasserting resumes from the frozen cnt, with no extra wrap.

## Test plan
- Reset check: assert rst mid-run with 2 samples buffered, then release.
  - During rst: pwm_o = 0, underrun_o = 0, ready_o = 1.
  - After release: the first wrap edge (cycle 255) with no push sets underrun_o.
- Single sample: push 0x40 at cycle 10 after reset.
  - Period starting at cnt == 0 following the first wrap: pwm_o high for exactly 64 cycles, then low for 192.
  - period_start_o pulses once every 256 cycles.
- Backpressure: hold valid_i high with samples 0x10, 0x20, 0x30.
  - The first two are accepted; ready_o drops to 0.
  - 0x30 is accepted in the cycle after the next wrap.
  - Periods play 0x10, 0x20, 0x30 in order.
- Extremes: samples 0x00 then 0xFF.
  - Period with 0x00: pwm_o is 0 for all 256 cycles.
  - Period with 0xFF: pwm_o is high 255 cycles, low 1.
- Underrun and clear:
  - Play 0x80, provide no further samples. Next period repeats 0x80 (128 high cycles) and underrun_o = 1.
  - clear_i pulsed in the same cycle as a new underrun: underrun_o stays 1.
  - clear_i pulsed alone later: underrun_o goes to 0.
- Enable gating: deassert enable_i at cnt = 100 for 50 cycles.
  - pwm_o = 0 and cnt holds throughout.
  - After re-enable, the wrap occurs 155 enabled cycles later, with no period_start_o pulse while disabled.
